// File: rtl/seven_seg_scan_mux_if.sv
// Avalon-MM slave port bundle for seven_seg_scan_mux.
// Zero-wait-state bus: a write is accepted on every rising clk edge where
// chipselect && write is high (there is no waitrequest, so the slave is
// always ready); readdata is valid in the same cycle as address
// (combinational, no read latency).
interface seven_seg_scan_mux_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        chipselect;
    logic [31:0] readdata;

    modport master (
        output address, write, writedata, chipselect,
        input  readdata
    );

    modport slave (
        input  address, write, writedata, chipselect,
        output readdata
    );
endinterface

// File: rtl/seven_seg_scan_mux.sv
// seven_seg_scan_mux: time-multiplexed driver for a common-anode,
// shared-segment multi-digit display. Scans one digit per dwell period
// (DIVIDER+1 cycles), with per-digit blanking and a CPU-visible status.
// Optional feature macro: SEVEN_SEG_GHOST_BLANK_EN -- darkens the first two
// cycles of every dwell to suppress ghosting between adjacent digits.
module seven_seg_scan_mux #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [15:0] DIV_RESET  = 16'd49999
) (
    input  logic                    clk,
    input  logic                    reset_n,
    seven_seg_scan_mux_if.slave     bus,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    // Register file
    logic                  ctrl_en;
    logic [NUM_DIGITS-1:0] blank;
    logic [15:0]           divider;

    // Scan state
    logic [15:0] prescaler;
    logic [2:0]  index;
    logic [7:0]  frame_cnt;

    // Bus decode
    logic wr_ctrl;
    logic wr_div;
    logic en_next;
    logic scan_run;
    logic reload;
    logic dead;

    // Digit selection
    logic [6:0]            cur_seg;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  lit;

    logic [31:0] rd_word;
    logic        unused_wd;

    assign wr_ctrl = bus.chipselect && bus.write && (bus.address == 2'd0);
    assign wr_div  = bus.chipselect && bus.write && (bus.address == 2'd1);

    // A CTRL write that clears ENABLE must win over a same-edge reload, so
    // the scanner only runs when ENABLE is set both now and after this edge.
    // This also gives a full first dwell after enabling.
    assign en_next  = wr_ctrl ? bus.writedata[0] : ctrl_en;
    assign scan_run = ctrl_en && en_next;
    assign reload   = scan_run && (prescaler == 16'd0);

    // Upper write-data bits carry no register fields.
    assign unused_wd = ^bus.writedata[31:16];

    // CPU-writable control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en <= 1'b0;
            blank   <= '0;
            divider <= DIV_RESET;
        end else begin
            if (wr_ctrl) begin
                ctrl_en <= bus.writedata[0];
                blank   <= bus.writedata[8 +: NUM_DIGITS];
            end
            if (wr_div) begin
                divider <= bus.writedata[15:0];
            end
        end
    end

    // Prescaler, digit index and frame counter; idle scanner sits at digit 0
    // with the prescaler preloaded so enabling starts a full dwell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= DIV_RESET;
            index     <= 3'd0;
            frame_cnt <= 8'd0;
        end else if (!scan_run) begin
            prescaler <= divider;
            index     <= 3'd0;
        end else if (prescaler == 16'd0) begin
            prescaler <= divider;
            if (index == LAST_IDX) begin
                index     <= 3'd0;
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                index <= index + 3'd1;
            end
        end else begin
            prescaler <= prescaler - 16'd1;
        end
    end

`ifdef SEVEN_SEG_GHOST_BLANK_EN
    logic [1:0] settle;

    // Counts the first cycles of each dwell (saturates at 2); dark until then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle <= 2'd0;
        end else if (!scan_run || reload) begin
            settle <= 2'd0;
        end else if (settle != 2'd2) begin
            settle <= settle + 2'd1;
        end
    end

    assign dead = (settle != 2'd2);
`else
    assign dead = 1'b0;
`endif

    // Pick the current digit's segments, blank bit and anode position
    always_comb begin
        cur_seg   = 7'd0;
        cur_blank = 1'b0;
        onehot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index == 3'(k)) begin
                cur_seg   = seg_in[7*k +: 7];
                cur_blank = blank[k];
                onehot[k] = 1'b1;
            end
        end
    end

    assign lit = ctrl_en && !cur_blank && !dead;

    // Registered active-low display drive; dark means every line high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_n  <= '1;
            seg_n <= '1;
        end else begin
            an_n  <= lit ? ~onehot : '1;
            seg_n <= lit ? ~cur_seg : 7'h7F;
        end
    end

    // Combinational read mux
    always_comb begin
        rd_word = 32'd0;
        case (bus.address)
            2'd0: begin
                rd_word[0]              = ctrl_en;
                rd_word[8 +: NUM_DIGITS] = blank;
            end
            2'd1: rd_word[15:0] = divider;
            2'd2: begin
                rd_word[2:0]  = index;
                rd_word[15:8] = frame_cnt;
            end
            default: rd_word = 32'd0;
        endcase
    end

    assign bus.readdata = rd_word;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Bench for seven_seg_scan_mux: directed literal checks plus a randomized
// run compared every cycle against a dwell-age model of the display.
module tb_seven_seg_scan_mux;

    localparam int          ND = 4;
    localparam logic [15:0] DR = 16'd49999;
    localparam int          W  = ND + 7;
`ifdef SEVEN_SEG_GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [7*ND-1:0] seg_in = '0;
    logic [6:0]      seg_n;
    logic [ND-1:0]   an_n;

    seven_seg_scan_mux_if bus();

    seven_seg_scan_mux #(.NUM_DIGITS(ND), .DIV_RESET(DR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .seg_in  (seg_in),
        .seg_n   (seg_n),
        .an_n    (an_n)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int total  = 0;
    int bad    = 0;
    int nprint = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (nprint < 40) begin
                nprint++;
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks each dwell by its age (cycles since it started) and its length
    // fixed when it started; outputs follow from that one cycle later.
    bit              m_en;
    logic [ND-1:0]   m_blank;
    logic [15:0]     m_div;
    int              m_idx, m_frame, m_age, m_len;
    logic [W-1:0]    exp_q[$];

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: begin r[0] = m_en; r[8 +: ND] = m_blank; end
            2'd1: r = {16'd0, m_div};
            2'd2: r = (32'(m_frame) << 8) | 32'(m_idx);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit          lit, wr_ctrl, wr_div, en_nx;
        logic [ND-1:0] an;
        logic [6:0]  sg;
        if (!reset_n) begin
            m_en = 1'b0; m_blank = '0; m_div = DR;
            m_idx = 0; m_frame = 0; m_age = 0; m_len = int'(DR) + 1;
            exp_q.delete();
            exp_q.push_back({W{1'b1}});
        end else begin
            lit = m_en && !m_blank[m_idx] && (!GHOST || m_age >= 2);
            an  = lit ? ~(ND'(1) << m_idx) : {ND{1'b1}};
            sg  = lit ? ~seg_in[m_idx*7 +: 7] : 7'h7F;
            exp_q.delete();
            exp_q.push_back({an, sg});

            wr_ctrl = bus.chipselect && bus.write && bus.address == 2'd0;
            wr_div  = bus.chipselect && bus.write && bus.address == 2'd1;
            en_nx   = wr_ctrl ? bus.writedata[0] : m_en;
            if (m_en && en_nx) begin
                if (m_age == m_len - 1) begin
                    m_age = 0;
                    m_len = int'(m_div) + 1;
                    if (m_idx == ND - 1) begin
                        m_idx = 0;
                        m_frame = (m_frame + 1) % 256;
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end else begin
                    m_age = m_age + 1;
                end
            end else begin
                m_age = 0;
                m_idx = 0;
                m_len = int'(m_div) + 1;
            end
            if (wr_ctrl) begin
                m_en    = bus.writedata[0];
                m_blank = bus.writedata[8 +: ND];
            end
            if (wr_div) m_div = bus.writedata[15:0];
        end
    end

    // Every-cycle compare of the DUT against the model
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (chk_on && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("an_n", 32'(an_n), 32'(e[W-1:7]));
            chk("seg_n", 32'(seg_n), 32'(e[6:0]));
            chk("readdata", bus.readdata, model_rd(bus.address));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        bus.chipselect = 1'b1; bus.write = 1'b0; bus.address = a;
        @(negedge clk);
        chk(name, bus.readdata, exp);
    endtask

    // Checks 16 consecutive cycles right after the enabling write; tables hold
    // digit 0 in the low field.
    task automatic frame_check(input string name, input logic [4*ND-1:0] an_tab,
                               input logic [7*ND-1:0] seg_tab);
        for (int k = 0; k < 16; k++) begin
            int d;
            bit lit;
            @(posedge clk); @(negedge clk);
            d   = k / 4;
            lit = !GHOST || (k % 4) >= 2;
            chk({name, "_an"}, 32'(an_n), lit ? 32'(an_tab[d*4 +: 4]) : 32'hF);
            chk({name, "_seg"}, 32'(seg_n), lit ? 32'(seg_tab[d*7 +: 7]) : 32'h7F);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.address = 2'd0; bus.write = 1'b0; bus.writedata = 32'd0; bus.chipselect = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_on = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        rd_check("rst_ctrl", 2'd0, 32'h0);
        rd_check("rst_div", 2'd1, 32'h0000C34F);
        rd_check("rst_status", 2'd2, 32'h0);
        rd_check("rst_rsvd", 2'd3, 32'h0);

        // Basic scan, DIVIDER=3
        seg_in = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'd1);
        frame_check("scan", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h30, 7'h24, 7'h79, 7'h40});
        rd_check("frame1_status", 2'd2, 32'h0000_0100);

        // Blank digits 0 and 2
        bus_write(2'd0, 32'd0);
        bus_write(2'd0, 32'h0000_0501);
        frame_check("blank", {4'b0111, 4'b1111, 4'b1101, 4'b1111},
                    {7'h30, 7'h7F, 7'h79, 7'h7F});

        // DIVIDER change mid-dwell, then disable on a reload edge
        bus_write(2'd0, 32'd0);
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'd1);
        bus_write(2'd1, 32'd7);
        repeat (8) @(posedge clk);
        bus_write(2'd0, 32'd0);
        bus.chipselect = 1'b1; bus.address = 2'd2;
        @(negedge clk);
        chk("disable_at_reload_idx", bus.readdata & 32'h7, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("disabled_an", 32'(an_n), 32'hF);
        chk("disabled_seg", 32'(seg_n), 32'h7F);

        // Asynchronous reset mid-frame (digit 2)
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'd1);
        repeat (9) @(posedge clk);
        #1 reset_n = 1'b0;
        bus.address = 2'd2;
        #1;
        chk("async_rst_an", 32'(an_n), 32'hF);
        chk("async_rst_seg", 32'(seg_n), 32'h7F);
        chk("async_rst_status", bus.readdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("post_rst_idle_an", 32'(an_n), 32'hF);
        rd_check("post_rst_ctrl", 2'd0, 32'h0);

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 1500; c++) begin
            int r;
            logic [31:0] wd;
            @(posedge clk); #1;
            seg_in = 28'($urandom);
            r = $urandom_range(0, 99);
            bus.write = 1'b0;
            bus.chipselect = 1'b0;
            bus.address = 2'($urandom_range(0, 3));
            bus.writedata = $urandom;
            if (r < 4) begin
                wd = $urandom;
                wd[0] = ($urandom_range(0, 4) != 0);
                bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 2'd0; bus.writedata = wd;
            end else if (r < 7) begin
                bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 2'd1;
                bus.writedata = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
            end else if (r < 9) begin
                bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 2'($urandom_range(2, 3));
            end else if (r < 12) begin
                bus.write = 1'b1;
            end else begin
                bus.chipselect = 1'($urandom_range(0, 1));
            end
        end

        @(posedge clk); #1;
        bus.write = 1'b0; bus.chipselect = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
